// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h53;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        PTR        = 4'd3,
        PTR_ACK    = 4'd4,
        WDATA      = 4'd5,
        WDATA_ACK  = 4'd6,
        RDATA      = 4'd7,
        RDATA_ACK  = 4'd8,
        RDATA_NACK = 4'd9
    } state_t;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pad, fabric write port and bus-write report of the I2C register-file target.
interface i2c_target_regfile_if #(
    parameter int unsigned AW = 4
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_wdata;
    logic          bus_wr_stb;
    logic [AW-1:0] bus_wr_addr;
    logic [7:0]    bus_wr_data;
    logic          busy;

    modport slave (
        input  scl_i, sda_i, loc_we, loc_addr, loc_wdata,
        output sda_oe, bus_wr_stb, bus_wr_addr, bus_wr_data, busy
    );

    modport master (
        output scl_i, sda_i, loc_we, loc_addr, loc_wdata,
        input  sda_oe, bus_wr_stb, bus_wr_addr, bus_wr_data, busy
    );
endinterface

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser plus FILT-cycle stability filter with edge pulses.
module i2c_in_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Lines idle high, so the synchroniser and level reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                lvl  <= sync2;
                cnt  <= '0;
                rise <= sync2;
                fall <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a 2^AW x 8 register bank; 7-bit addressing, no clock stretching.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned AW       = 4,
    parameter int unsigned FILT     = 3
) (
    input logic                 clk_clk,
    input logic                 reset_reset,
    i2c_target_regfile_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    state_t                state, state_n;
    logic [BIT_CNT_W-1:0]  bitcnt, bitcnt_n;
    logic [BYTE_W-1:0]     shift, shift_n;
    logic [BYTE_W-1:0]     tx, tx_n;
    logic [AW-1:0]         ptr, ptr_n, ptr_inc;
    logic                  mack, mack_n;
    logic                  sda_oe_q, oe_n;
    logic                  busy_q, busy_n;
    logic                  stb_q, stb_n;
    logic [AW-1:0]         waddr_q, waddr_n;
    logic [BYTE_W-1:0]     wdata_q, wdata_n;
    logic                  bus_we_c;

    logic [BYTE_W-1:0]     bank [DEPTH];

    i2c_in_filter #(.FILT(FILT)) u_scl_filt (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .din  (bus.scl_i),
        .lvl  (scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_in_filter #(.FILT(FILT)) u_sda_filt (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .din  (bus.sda_i),
        .lvl  (sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;
    assign ptr_inc = ptr + 1'b1;

    assign bus.sda_oe      = sda_oe_q;
    assign bus.busy        = busy_q;
    assign bus.bus_wr_stb  = stb_q;
    assign bus.bus_wr_addr = waddr_q;
    assign bus.bus_wr_data = wdata_q;

    // State and datapath registers; SDA is released immediately on reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shift    <= '0;
            tx       <= '0;
            ptr      <= '0;
            mack     <= NACK;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            stb_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            shift    <= shift_n;
            tx       <= tx_n;
            ptr      <= ptr_n;
            mack     <= mack_n;
            sda_oe_q <= oe_n;
            busy_q   <= busy_n;
            stb_q    <= stb_n;
            waddr_q  <= waddr_n;
            wdata_q  <= wdata_n;
        end
    end

    // Next-state logic: bits in on SCL rise, SDA drive changes on SCL fall.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        tx_n     = tx;
        ptr_n    = ptr;
        mack_n   = mack;
        oe_n     = sda_oe_q;
        busy_n   = busy_q;
        stb_n    = 1'b0;
        waddr_n  = waddr_q;
        wdata_n  = wdata_q;
        bus_we_c = 1'b0;

        if (stop_c) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            oe_n     = 1'b0;
            busy_n   = 1'b0;
        end else if (start_c) begin
            state_n  = ADDR;
            bitcnt_n = '0;
            oe_n     = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bitcnt != BITS_PER_BYTE) begin
                        shift_n  = {shift[BYTE_W-2:0], sda_lvl};
                        bitcnt_n = bitcnt + 1'b1;
                    end else if (scl_fall && bitcnt == BITS_PER_BYTE) begin
                        bitcnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR && shift[7:1] != 7'd0) begin
                                state_n = ADDR_ACK;
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IDLE;
                                busy_n  = 1'b0;
                            end
                        end else if (state == PTR) begin
                            state_n = PTR_ACK;
                            oe_n    = 1'b1;
                            ptr_n   = shift[AW-1:0];
                        end else begin
                            state_n  = WDATA_ACK;
                            oe_n     = 1'b1;
                            bus_we_c = 1'b1;
                            stb_n    = 1'b1;
                            waddr_n  = ptr;
                            wdata_n  = shift;
                            ptr_n    = ptr_inc;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_n = '0;
                        if (shift[0]) begin
                            state_n = RDATA;
                            tx_n    = bank[ptr];
                            oe_n    = ~bank[ptr][7];
                        end else begin
                            state_n = PTR;
                            oe_n    = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_n  = WDATA;
                        bitcnt_n = '0;
                        oe_n     = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && bitcnt != BITS_PER_BYTE) begin
                        bitcnt_n = bitcnt + 1'b1;
                    end else if (scl_fall) begin
                        if (bitcnt == BITS_PER_BYTE) begin
                            state_n = RDATA_ACK;
                            oe_n    = 1'b0;
                        end else begin
                            tx_n = {tx[BYTE_W-2:0], 1'b0};
                            oe_n = ~tx[BYTE_W-2];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_lvl;
                    end else if (scl_fall) begin
                        if (mack == ACK) begin
                            state_n  = RDATA;
                            bitcnt_n = '0;
                            ptr_n    = ptr_inc;
                            tx_n     = bank[ptr_inc];
                            oe_n     = ~bank[ptr_inc][7];
                        end else begin
                            state_n = RDATA_NACK;
                            oe_n    = 1'b0;
                        end
                    end
                end
                IDLE, RDATA_NACK: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    // Register bank; a bus write to the same address overrides the fabric write.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (bus.loc_we) begin
                bank[bus.loc_addr] <= bus.loc_wdata;
            end
            if (bus_we_c) begin
                bank[ptr] <= shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboard bench: bit-banged I2C master with pull-ups; monitor compares DUT outputs.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int unsigned AW = 4;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;
    int   tq        = 625;

    int checks = 0;
    int fails  = 0;

    logic oe_seen   = 1'b0;
    logic busy_seen = 1'b0;

    logic [11:0] exp_stb_q[$];
    logic        exp_ack_q[$];
    logic        act_ack_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  act_rd_q[$];

    i2c_target_regfile_if #(.AW(AW)) ifc ();

    i2c_target_regfile #(.DEV_ADDR(7'h53), .AW(AW), .FILT(3)) dut (
        .clk_clk     (clk),
        .reset_reset (reset),
        .bus         (ifc.slave)
    );

    always #10 clk = ~clk;

    assign ifc.scl_i = m_scl_low ? 1'b0 : 1'b1;
    assign ifc.sda_i = (m_sda_low || ifc.sda_oe) ? 1'b0 : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: strobes, ACK bits and read bytes are popped against expectations.
    always @(negedge clk) begin
        logic [11:0] e;
        if (ifc.sda_oe) oe_seen = 1'b1;
        if (ifc.busy) busy_seen = 1'b1;
        if (!reset && ifc.bus_wr_stb) begin
            if (exp_stb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_strobe: got addr=0x%0h data=0x%0h, required no strobe",
                         ifc.bus_wr_addr, ifc.bus_wr_data);
            end else begin
                e = exp_stb_q.pop_front();
                check("bus_write", 32'({ifc.bus_wr_addr, ifc.bus_wr_data}), 32'(e));
            end
        end
        while (act_ack_q.size() > 0 && exp_ack_q.size() > 0)
            check("ack_bit", 32'(act_ack_q.pop_front()), 32'(exp_ack_q.pop_front()));
        while (act_rd_q.size() > 0 && exp_rd_q.size() > 0)
            check("read_byte", 32'(act_rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
    end

    task automatic i2c_start();
        m_sda_low = 1'b0;
        #(tq);
        m_scl_low = 1'b0;
        #(2 * tq);
        m_sda_low = 1'b1;
        #(2 * tq);
        m_scl_low = 1'b1;
        #(tq);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        #(tq);
        m_scl_low = 1'b0;
        #(2 * tq);
        m_sda_low = 1'b0;
        #(2 * tq);
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b;
        #(tq);
        m_scl_low = 1'b0;
        #(2 * tq);
        m_scl_low = 1'b1;
        #(tq);
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0;
        #(tq);
        m_scl_low = 1'b0;
        #(tq);
        b = ifc.sda_i;
        #(tq);
        m_scl_low = 1'b1;
        #(tq);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        act_ack_q.push_back(a);
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] v;
        logic       b;
        exp_rd_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(ack);
        act_rd_q.push_back(v);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.loc_we    = 1'b0;
        ifc.loc_addr  = '0;
        ifc.loc_wdata = '0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 32'(ifc.sda_oe), 32'd0);
        check("rst_stb", 32'(ifc.bus_wr_stb), 32'd0);
        check("rst_wr_addr", 32'(ifc.bus_wr_addr), 32'd0);
        check("rst_wr_data", 32'(ifc.bus_wr_data), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        settle();

        // 1: write at 100 kHz
        tq = 2500;
        i2c_start();
        wr_byte(8'hA6, ACK);
        check("busy_addressed", 32'(ifc.busy), 32'd1);
        wr_byte(8'h02, ACK);
        exp_stb_q.push_back({4'h2, 8'h5A});
        wr_byte(8'h5A, ACK);
        exp_stb_q.push_back({4'h3, 8'hC3});
        wr_byte(8'hC3, ACK);
        i2c_stop();
        settle();
        check("busy_after_stop", 32'(ifc.busy), 32'd0);
        check("bank2", 32'(dut.bank[2]), 32'h5A);
        check("bank3", 32'(dut.bank[3]), 32'hC3);

        // 2: pointer then repeated-start read at 400 kHz
        tq = 625;
        @(negedge clk);
        ifc.loc_we = 1'b1; ifc.loc_addr = 4'h0; ifc.loc_wdata = 8'hE5;
        @(negedge clk);
        ifc.loc_addr = 4'h1; ifc.loc_wdata = 8'h11;
        @(negedge clk);
        ifc.loc_we = 1'b0;
        i2c_start();
        wr_byte(8'hA6, ACK);
        wr_byte(8'h00, ACK);
        i2c_start();
        wr_byte(8'hA7, ACK);
        rd_byte(8'hE5, ACK);
        rd_byte(8'h11, NACK);
        check("sda_released_after_nack", 32'(ifc.sda_oe), 32'd0);
        i2c_stop();
        settle();

        // 3: wrong address
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'h3A, NACK);
        i2c_stop();
        settle();
        check("wrong_addr_sda_oe", 32'(oe_seen), 32'd0);
        check("wrong_addr_busy", 32'(busy_seen), 32'd0);

        // 4: pointer wrap
        i2c_start();
        wr_byte(8'hA6, ACK);
        wr_byte(8'h0F, ACK);
        exp_stb_q.push_back({4'hF, 8'hAA});
        wr_byte(8'hAA, ACK);
        exp_stb_q.push_back({4'h0, 8'hBB});
        wr_byte(8'hBB, ACK);
        i2c_stop();
        settle();
        check("bank15", 32'(dut.bank[15]), 32'hAA);
        check("bank0_wrapped", 32'(dut.bank[0]), 32'hBB);

        // 5: STOP after a partial byte, then a valid transfer
        i2c_start();
        wr_byte(8'hA6, ACK);
        wr_byte(8'h05, ACK);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        i2c_stop();
        settle();
        check("partial_state_idle", 32'(dut.state), 32'(IDLE));
        check("partial_no_write", 32'(dut.bank[5]), 32'h00);
        i2c_start();
        wr_byte(8'hA6, ACK);
        wr_byte(8'h05, ACK);
        exp_stb_q.push_back({4'h5, 8'h77});
        wr_byte(8'h77, ACK);
        i2c_stop();
        settle();
        check("bank5_after_partial", 32'(dut.bank[5]), 32'h77);

        // 6a: one-cycle SDA glitch on an idle bus
        @(negedge clk);
        m_sda_low = 1'b1;
        @(negedge clk);
        m_sda_low = 1'b0;
        settle();
        check("glitch_no_start", 32'(dut.state), 32'(IDLE));

        // 6b: reset while the target drives SDA low during a read (bank[2]=5A, MSB 0)
        i2c_start();
        wr_byte(8'hA6, ACK);
        wr_byte(8'h02, ACK);
        i2c_start();
        wr_byte(8'hA7, ACK);
        @(negedge clk);
        check("oe_before_reset", 32'(ifc.sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        check("oe_cleared_by_reset", 32'(ifc.sda_oe), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) check("bank_cleared", 32'(dut.bank[i]), 32'd0);
        check("busy_after_reset", 32'(ifc.busy), 32'd0);
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        settle();

        check("stb_queue_drained", 32'(exp_stb_q.size()), 32'd0);
        check("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
